// File: rtl/trapint_ctrl_pkg.sv
// Shared constants for the interrupt-trap controller: standard mip bit indices,
// fixed selection order, privilege encodings and WFI state encodings.
package trapint_ctrl_pkg;

  localparam int SSI  = 1;
  localparam int VSSI = 2;
  localparam int MSI  = 3;
  localparam int STI  = 5;
  localparam int VSTI = 6;
  localparam int MTI  = 7;
  localparam int SEI  = 9;
  localparam int VSEI = 10;
  localparam int MEI  = 11;
  localparam int SGEI = 12;

  localparam int NUM_STD = 10;
  // Highest priority first; custom lines (>=13) rank below all of these.
  localparam int PRIO_ORDER [NUM_STD] = '{MEI, MSI, MTI, SEI, SSI, STI, SGEI, VSEI, VSSI, VSTI};
  // Bits 0, 4 and 8 are never selectable.
  localparam logic [12:0] STD_HOLES = 13'h0111;

  localparam logic [1:0] PRIV_U = 2'b00;
  localparam logic [1:0] PRIV_S = 2'b01;
  localparam logic [1:0] PRIV_M = 2'b11;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, TOUT = 2'd2} wfi_state_t;

  localparam logic [1:0] WFI_IDLE = IDLE;
  localparam logic [1:0] WFI_WAIT = WAIT;
  localparam logic [1:0] WFI_TOUT = TOUT;

  function automatic logic isVsCode(input int idx);
    return (idx == VSSI) || (idx == VSTI) || (idx == VSEI);
  endfunction

endpackage

// File: rtl/trapint_ctrl_if.sv
// Bundle between the CSR/pipeline side (master) and the interrupt-trap controller (slave).
// Plain level signals, no handshake: every input is sampled each cycle, outputs are combinational.
interface trapint_ctrl_if #(
  parameter int NUM_INTS   = 16,
  parameter int CAUSE_BITS = 6
);
  logic                  StallW;
  logic                  FlushW;
  logic [1:0]            PrivilegeModeW;
  logic                  VirtModeW;
  logic                  STATUS_MIE;
  logic                  STATUS_SIE;
  logic                  VSSTATUS_SIE;
  logic                  STATUS_TW;
  logic [NUM_INTS-1:0]   MIP_REGW;
  logic [NUM_INTS-1:0]   MIE_REGW;
  logic [NUM_INTS-1:0]   MIDELEG_REGW;
  logic [NUM_INTS-1:0]   HIDELEG_REGW;
  logic                  InstrValidM;
  logic                  CommittedM;
  logic                  CommittedF;
  logic                  wfiM;
  logic                  ExceptionM;
  logic                  InterruptM;
  logic [CAUSE_BITS-1:0] IntCauseM;
  logic                  IntToM;
  logic                  IntToHS;
  logic                  IntToVS;
  logic                  IntPendingM;
  logic                  WfiStallM;
  logic                  WfiTimeoutM;

  modport master (
    output StallW, FlushW, PrivilegeModeW, VirtModeW, STATUS_MIE, STATUS_SIE,
           VSSTATUS_SIE, STATUS_TW, MIP_REGW, MIE_REGW, MIDELEG_REGW, HIDELEG_REGW,
           InstrValidM, CommittedM, CommittedF, wfiM, ExceptionM,
    input  InterruptM, IntCauseM, IntToM, IntToHS, IntToVS, IntPendingM,
           WfiStallM, WfiTimeoutM
  );

  modport slave (
    input  StallW, FlushW, PrivilegeModeW, VirtModeW, STATUS_MIE, STATUS_SIE,
           VSSTATUS_SIE, STATUS_TW, MIP_REGW, MIE_REGW, MIDELEG_REGW, HIDELEG_REGW,
           InstrValidM, CommittedM, CommittedF, wfiM, ExceptionM,
    output InterruptM, IntCauseM, IntToM, IntToHS, IntToVS, IntPendingM,
           WfiStallM, WfiTimeoutM
  );
endinterface

// File: rtl/trapint_ctrl_intprio.sv
// Fixed-order priority encoder: standard lines in architectural order,
// then custom lines with the highest index winning.
module trapint_ctrl_intprio
  import trapint_ctrl_pkg::*;
#(
  parameter int NUM_INTS   = 16,
  parameter int CAUSE_BITS = 6
) (
  input  logic [NUM_INTS-1:0]   pend,
  output logic                  any,
  output logic [CAUSE_BITS-1:0] idx
);

  localparam logic [NUM_INTS-1:0] PRIO_MASK = ~NUM_INTS'(STD_HOLES);

  always_comb begin
    any = |(pend & PRIO_MASK);
    idx = '0;
    for (int i = 13; i < NUM_INTS; i++) begin
      if (pend[i]) idx = CAUSE_BITS'(i);
    end
    // Walk lowest-priority standard line first so the highest one overwrites.
    for (int k = NUM_STD - 1; k >= 0; k--) begin
      if (pend[PRIO_ORDER[k]]) idx = CAUSE_BITS'(PRIO_ORDER[k]);
    end
  end

endmodule

// File: rtl/trapint_ctrl.sv
// Interrupt-trap controller: registered pending stage, M/HS/VS delegation and
// target selection, plus the WFI wait/timeout state machine.
module trapint_ctrl
  import trapint_ctrl_pkg::*;
#(
  parameter int NUM_INTS    = 16,
  parameter int H_SUPPORTED = 1,
  parameter int WFI_TIMEOUT = 255,
  parameter int CAUSE_BITS  = 6
) (
  input  logic            clk,
  input  logic            reset,
  trapint_ctrl_if.slave   bus,
  output logic [1:0]      wfiState
);

  localparam int CNT_W = (WFI_TIMEOUT > 0) ? $clog2(WFI_TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WFI_TIMEOUT);

  logic [NUM_INTS-1:0]   pendQ, hideleg, mSet, hsSet, vsSet;
  logic                  virt, privM, privS, privU;
  logic                  mGlobal, hsGlobal, vsGlobal;
  logic                  mAny, hsAny, vsAny, twArmed;
  logic [CAUSE_BITS-1:0] mIdx, hsIdx, vsIdx, vsCause;
  logic [1:0]            state, stateNext;
  logic [CNT_W-1:0]      cnt, cntNext;

  always_ff @(posedge clk) begin
    if (reset) pendQ <= '0;
    else       pendQ <= bus.MIP_REGW & bus.MIE_REGW;
  end

  assign virt    = (H_SUPPORTED != 0) & bus.VirtModeW;
  assign hideleg = (H_SUPPORTED != 0) ? bus.HIDELEG_REGW : '0;
  assign privM   = (bus.PrivilegeModeW == PRIV_M);
  assign privS   = (bus.PrivilegeModeW == PRIV_S);
  assign privU   = (bus.PrivilegeModeW == PRIV_U);

  assign mGlobal  = ~privM | bus.STATUS_MIE;
  assign hsGlobal = ~privM & (virt | privU | (privS & bus.STATUS_SIE));
  assign vsGlobal = virt & (privU | (privS & bus.VSSTATUS_SIE));

  assign mSet  = pendQ & ~bus.MIDELEG_REGW & {NUM_INTS{mGlobal}};
  assign hsSet = pendQ & bus.MIDELEG_REGW & ~hideleg & {NUM_INTS{hsGlobal}};
  assign vsSet = pendQ & bus.MIDELEG_REGW & hideleg & {NUM_INTS{vsGlobal}};

  trapint_ctrl_intprio #(.NUM_INTS(NUM_INTS), .CAUSE_BITS(CAUSE_BITS)) uPrioM  (.pend(mSet),  .any(mAny),  .idx(mIdx));
  trapint_ctrl_intprio #(.NUM_INTS(NUM_INTS), .CAUSE_BITS(CAUSE_BITS)) uPrioHS (.pend(hsSet), .any(hsAny), .idx(hsIdx));
  trapint_ctrl_intprio #(.NUM_INTS(NUM_INTS), .CAUSE_BITS(CAUSE_BITS)) uPrioVS (.pend(vsSet), .any(vsAny), .idx(vsIdx));

  // VS-level standard interrupts are reported to the guest with their S-level codes.
  assign vsCause = isVsCode(int'(vsIdx)) ? vsIdx - CAUSE_BITS'(1) : vsIdx;

  always_comb begin
    bus.InterruptM = (mAny | hsAny | vsAny) & ~bus.ExceptionM & ~bus.CommittedM &
                     ~bus.CommittedF & (bus.InstrValidM | (state == WFI_WAIT));
    bus.IntToM  = bus.InterruptM & mAny;
    bus.IntToHS = bus.InterruptM & ~mAny & hsAny;
    bus.IntToVS = bus.InterruptM & ~mAny & ~hsAny & vsAny;
    bus.IntCauseM = '0;
    if (bus.IntToM)       bus.IntCauseM = mIdx;
    else if (bus.IntToHS) bus.IntCauseM = hsIdx;
    else if (bus.IntToVS) bus.IntCauseM = vsCause;
  end

  assign bus.IntPendingM = |pendQ;
  assign twArmed         = bus.STATUS_TW & ~privM;

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    case (state)
      WFI_IDLE: begin
        cntNext = '0;
        if (bus.wfiM & bus.InstrValidM & ~bus.IntPendingM & ~bus.FlushW) stateNext = WFI_WAIT;
      end
      WFI_WAIT: begin
        // A wake-up outranks a timeout landing in the same cycle.
        if (bus.IntPendingM) begin
          stateNext = WFI_IDLE;
          cntNext   = '0;
        end else if (twArmed & (cnt == CNT_MAX)) begin
          stateNext = WFI_TOUT;
          cntNext   = '0;
        end else if (twArmed) begin
          cntNext = cnt + CNT_W'(1);
        end
      end
      default: begin
        stateNext = WFI_IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || bus.FlushW) begin
      state <= WFI_IDLE;
      cnt   <= '0;
    end else if (!bus.StallW) begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  assign bus.WfiStallM   = (state == WFI_WAIT);
  assign bus.WfiTimeoutM = (state == WFI_TOUT);
  assign wfiState        = state;

endmodule

// File: tb/tb_trapint_ctrl.sv
// Directed bench for trapint_ctrl: pending latency, priority order, delegation
// targets, exception precedence and the WFI wait/timeout/wake paths.
module tb_trapint_ctrl;
  import trapint_ctrl_pkg::*;

  localparam int NI = 16;
  localparam int CB = 6;
  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] wfiState;
  int         nAsserts = 0;
  int         nFail = 0;

  trapint_ctrl_if #(.NUM_INTS(NI), .CAUSE_BITS(CB)) bif ();

  trapint_ctrl #(
    .NUM_INTS(NI), .H_SUPPORTED(1), .WFI_TIMEOUT(TO), .CAUSE_BITS(CB)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bif),
    .wfiState(wfiState)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cycle();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic setIrq(input logic [NI-1:0] mip, input logic [NI-1:0] mie);
    bif.MIP_REGW = mip;
    bif.MIE_REGW = mie;
  endtask

  task automatic clearAll();
    bif.StallW = 0; bif.FlushW = 0; bif.PrivilegeModeW = PRIV_U; bif.VirtModeW = 0;
    bif.STATUS_MIE = 0; bif.STATUS_SIE = 0; bif.VSSTATUS_SIE = 0; bif.STATUS_TW = 0;
    bif.MIP_REGW = '0; bif.MIE_REGW = '0; bif.MIDELEG_REGW = '0; bif.HIDELEG_REGW = '0;
    bif.InstrValidM = 1; bif.CommittedM = 0; bif.CommittedF = 0; bif.wfiM = 0;
    bif.ExceptionM = 0;
  endtask

  initial begin
    clearAll();
    reset = 1;
    cycle(); cycle();
    chk("rst_int",     bif.InterruptM,  0);
    chk("rst_cause",   bif.IntCauseM,   0);
    chk("rst_tom",     bif.IntToM,      0);
    chk("rst_pend",    bif.IntPendingM, 0);
    chk("rst_stall",   bif.WfiStallM,   0);
    chk("rst_tout",    bif.WfiTimeoutM, 0);
    chk("rst_state",   wfiState,        WFI_IDLE);
    reset = 0;

    // MTI in U-mode, one cycle of pending latency
    setIrq(16'h0080, 16'h0080);
    settle();
    chk("mti_latency", bif.InterruptM, 0);
    cycle();
    chk("mti_int",   bif.InterruptM, 1);
    chk("mti_cause", bif.IntCauseM,  7);
    chk("mti_tom",   bif.IntToM,     1);
    chk("mti_tohs",  bif.IntToHS,    0);
    chk("mti_tovs",  bif.IntToVS,    0);

    // M-mode global enable and fixed priority order
    bif.PrivilegeModeW = PRIV_M;
    setIrq(16'h0888, 16'h0888);
    cycle();
    chk("mmode_off_int",  bif.InterruptM,  0);
    chk("mmode_off_pend", bif.IntPendingM, 1);
    bif.STATUS_MIE = 1;
    settle();
    chk("mmode_on_int",   bif.InterruptM, 1);
    chk("mmode_on_cause", bif.IntCauseM,  11);
    setIrq(16'h0088, 16'h0888);
    cycle();
    chk("prio_3_over_7", bif.IntCauseM, 3);
    setIrq(16'h0280, 16'h0280);
    cycle();
    chk("prio_7_over_9", bif.IntCauseM, 7);
    setIrq(16'hA004, 16'hA004);
    cycle();
    chk("prio_std_over_custom", bif.IntCauseM, 2);
    setIrq(16'hA000, 16'hA000);
    cycle();
    chk("prio_custom_high", bif.IntCauseM, 15);

    // VS / HS delegation
    bif.STATUS_MIE = 0;
    bif.PrivilegeModeW = PRIV_S;
    bif.VirtModeW = 1;
    bif.VSSTATUS_SIE = 1;
    bif.MIDELEG_REGW = 16'h0400;
    bif.HIDELEG_REGW = 16'h0400;
    setIrq(16'h0400, 16'h0400);
    cycle();
    chk("vs_int",   bif.InterruptM, 1);
    chk("vs_tovs",  bif.IntToVS,    1);
    chk("vs_cause", bif.IntCauseM,  9);
    bif.VSSTATUS_SIE = 0;
    settle();
    chk("vs_masked", bif.InterruptM, 0);
    bif.HIDELEG_REGW = '0;
    settle();
    chk("hs_tohs",  bif.IntToHS,   1);
    chk("hs_cause", bif.IntCauseM, 10);
    setIrq(16'h0480, 16'h0480);
    cycle();
    chk("m_over_hs_tom",   bif.IntToM,    1);
    chk("m_over_hs_cause", bif.IntCauseM, 7);

    // exception and commit blocking
    clearAll();
    setIrq(16'h0080, 16'h0080);
    bif.ExceptionM = 1;
    cycle();
    chk("exc_blocks",  bif.InterruptM,  0);
    chk("exc_pend",    bif.IntPendingM, 1);
    bif.ExceptionM = 0;
    settle();
    chk("exc_release", bif.InterruptM, 1);
    bif.CommittedF = 1;
    settle();
    chk("commitf_blocks", bif.InterruptM, 0);
    bif.CommittedF = 0;
    bif.InstrValidM = 0;
    settle();
    chk("novalid_blocks", bif.InterruptM, 0);

    // WFI with TW timeout
    clearAll();
    bif.PrivilegeModeW = PRIV_S;
    bif.STATUS_TW = 1;
    cycle();
    bif.wfiM = 1;
    settle();
    chk("wfi_pre_idle", wfiState, WFI_IDLE);
    cycle();
    bif.wfiM = 0;
    bif.InstrValidM = 0;
    for (int c = 0; c < TO + 1; c++) begin
      chk($sformatf("wfi_stall_%0d", c), bif.WfiStallM,   1);
      chk($sformatf("wfi_notout_%0d", c), bif.WfiTimeoutM, 0);
      cycle();
    end
    chk("wfi_tout_pulse", bif.WfiTimeoutM, 1);
    chk("wfi_tout_nostall", bif.WfiStallM, 0);
    chk("wfi_tout_state", wfiState, WFI_TOUT);
    cycle();
    chk("wfi_tout_done", bif.WfiTimeoutM, 0);
    chk("wfi_back_idle", wfiState, WFI_IDLE);

    // WFI wake on the cycle the counter reaches the timeout
    setIrq(16'h0000, 16'h0008);
    bif.InstrValidM = 1;
    bif.wfiM = 1;
    cycle();
    bif.wfiM = 0;
    bif.InstrValidM = 0;
    for (int c = 0; c < TO + 1; c++) begin
      chk($sformatf("wake_stall_%0d", c), bif.WfiStallM, 1);
      if (c == TO) begin
        chk("wake_pend",  bif.IntPendingM, 1);
        chk("wake_int",   bif.InterruptM,  1);
        chk("wake_cause", bif.IntCauseM,   3);
        chk("wake_tom",   bif.IntToM,      1);
      end
      if (c == TO - 1) bif.MIP_REGW = 16'h0008;
      cycle();
    end
    chk("wake_no_tout", bif.WfiTimeoutM, 0);
    chk("wake_idle",    wfiState,        WFI_IDLE);
    chk("wake_nostall", bif.WfiStallM,   0);

    // WFI with interrupt already pending retires as a NOP
    bif.InstrValidM = 1;
    bif.wfiM = 1;
    cycle();
    chk("nop_idle",  wfiState,      WFI_IDLE);
    chk("nop_stall", bif.WfiStallM, 0);
    bif.wfiM = 0;

    // StallW freezes the counter; FlushW aborts the wait
    bif.MIP_REGW = '0;
    cycle();
    bif.wfiM = 1;
    cycle();
    bif.wfiM = 0;
    chk("flush_pre_wait", wfiState, WFI_WAIT);
    bif.StallW = 1;
    for (int c = 0; c < 8; c++) cycle();
    chk("stall_holds_wait", wfiState, WFI_WAIT);
    bif.StallW = 0;
    bif.FlushW = 1;
    cycle();
    chk("flush_idle", wfiState, WFI_IDLE);
    bif.FlushW = 0;

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
